// File: rtl/div_sched_pkg.sv
// Shared definitions for the divided-clock scheduler: FSM encoding,
// default counter width and the divide ratio loaded at reset.
package div_sched_pkg;

   localparam int DS_W           = 4;
   localparam int DS_DIV_DEFAULT = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

endpackage

// File: rtl/div_sched_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from the
// request lines; the priority pointer flips after every issued grant.
module rr_arb2
   import div_sched_pkg::*;
(
   input  logic       clk_in,
   input  logic       clr,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;
   logic ptr_d;

   // Pick the favoured requester first, fall back to the other one.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (ptr_q) begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
         end else begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
         end
      end
      ptr_d = ptr_q ^ (gnt_o != 2'b00);
   end

   // Pointer register; requester 0 is favoured after reset.
   always_ff @(posedge clk_in or posedge clr) begin
      if (clr) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/div_sched.sv
// Programmable clock divider with two arbitrated ratio-change requesters.
// Ratio changes granted while running wait in PEND until the current
// clk_out period ends, so a period is never cut short.
//
// Handshake: a requester holds req[i] (and its div_x) until gnt[i] pulses;
// the ratio is captured on that same cycle and the requester drops req[i]
// on the following cycle. No grants are issued while in PEND.
module div_sched
   import div_sched_pkg::*;
#(
   parameter int W           = DS_W,
   parameter int DIV_DEFAULT = DS_DIV_DEFAULT
) (
   input  logic         clk_in,
   input  logic         clr,
   input  logic         en,
   input  logic [1:0]   req,
   input  logic [W-1:0] div_a,
   input  logic [W-1:0] div_b,
   output logic [1:0]   gnt,
   output logic         err,
   output logic         clk_out,
   output logic         tick,
   output logic         busy,
   output logic [W-1:0] cur_div,
   output logic [1:0]   dbg_state
);

   localparam logic [W-1:0] DIV_RST = W'(DIV_DEFAULT);

   state_t       st_q, st_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] cur_q, cur_d;
   logic [W-1:0] pend_q, pend_d;
   logic         clk_out_q, clk_out_d;
   logic         tick_q, tick_d;

   logic         arb_en;
   logic         g_any;
   logic         g_valid;
   logic [W-1:0] g_div;
   logic         last;

   assign arb_en = !clr && (st_q != ST_PEND);

   rr_arb2 u_arb (
      .clk_in (clk_in),
      .clr    (clr),
      .req_i  (req),
      .en_i   (arb_en),
      .gnt_o  (gnt)
   );

   assign g_any   = |gnt;
   assign g_div   = gnt[1] ? div_b : div_a;
   assign g_valid = g_any && (g_div >= W'(2));
   assign err     = g_any && !g_valid;
   assign last    = (cnt_q == cur_q - W'(1));

   // Next-state logic; clk_out and tick are derived from the next
   // counter/ratio so their registers line up with cnt_q/cur_q.
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      cur_d  = cur_q;
      pend_d = pend_q;
      case (st_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (g_valid) cur_d = g_div;
            if (en)      st_d  = ST_RUN;
         end
         ST_RUN: begin
            if (!en) begin
               // Stopping: a ratio granted now can take effect directly.
               st_d  = ST_IDLE;
               cnt_d = '0;
               if (g_valid) cur_d = g_div;
            end else begin
               cnt_d = last ? '0 : cnt_q + W'(1);
               if (g_valid) begin
                  pend_d = g_div;
                  st_d   = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (!en) begin
               st_d  = ST_IDLE;
               cnt_d = '0;
               cur_d = pend_q;
            end else if (last) begin
               st_d  = ST_RUN;
               cnt_d = '0;
               cur_d = pend_q;
            end else begin
               cnt_d = cnt_q + W'(1);
            end
         end
         default: begin
            st_d  = ST_IDLE;
            cnt_d = '0;
         end
      endcase
      clk_out_d = (st_d != ST_IDLE) && (cnt_d < (cur_d >> 1));
      tick_d    = (st_d != ST_IDLE) && (cnt_d == cur_d - W'(1));
   end

   // State and registered outputs.
   always_ff @(posedge clk_in or posedge clr) begin
      if (clr) begin
         st_q      <= ST_IDLE;
         cnt_q     <= '0;
         cur_q     <= DIV_RST;
         pend_q    <= DIV_RST;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         cur_q     <= cur_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign busy      = (st_q == ST_PEND);
   assign cur_div   = cur_q;
   assign dbg_state = st_q;

endmodule
